regfile_arb: RTL and testbench

//  Two-master arbiter for the single-port register file in the REF_CLK domain.

---
 rtl/regfile_arb.sv | 159 +++++++++++++++
 tb/tb_regfile_arb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arb.sv
// Two-master round-robin arbiter for the single-port RegFile, with a read-response timeout.
// Optional burst ownership via the REGFILE_ARB_LOCK_EN macro (adds M0_LOCK/M1_LOCK).
module regfile_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  M0_REQ,
  input  logic                  M0_WR,
  input  logic [ADDR_WIDTH-1:0] M0_ADDR,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  input  logic                  M1_REQ,
  input  logic                  M1_WR,
  input  logic [ADDR_WIDTH-1:0] M1_ADDR,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic                  M0_LOCK,
  input  logic                  M1_LOCK,
`endif
  output logic                  M0_GNT,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic                  M0_RVALID,
  output logic                  M1_GNT,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic                  M1_RVALID,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VALID,
  output logic                  RD_ERR,
  output logic                  ARB_BUSY
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  typedef enum logic {MST_M0, MST_M1} mst_t;

  localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

  state_t state, state_nxt;
  mst_t   last_gnt, win;
  logic   [7:0] rd_cnt;

  logic                  any_req, issue_now, rd_fin, rd_to;
  logic                  win_wr;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata, rdata_sel;

  logic                  m0_gnt_nxt, m1_gnt_nxt, m0_rvalid_nxt, m1_rvalid_nxt;
  logic [DATA_WIDTH-1:0] m0_rdata_nxt, m1_rdata_nxt, rf_wr_data_nxt;
  logic [ADDR_WIDTH-1:0] rf_addr_nxt;
  logic                  rf_wr_en_nxt, rf_rd_en_nxt, rd_err_nxt, busy_nxt;

  assign any_req = M0_REQ | M1_REQ;

  // last_gnt doubles as the owner of the command in flight.
  always_comb begin
    win = (last_gnt == MST_M1) ? MST_M0 : MST_M1;
    if (!M1_REQ)
      win = MST_M0;
    else if (!M0_REQ)
      win = MST_M1;
`ifdef REGFILE_ARB_LOCK_EN
    else if (last_gnt == MST_M0 && M0_LOCK)
      win = MST_M0;
    else if (last_gnt == MST_M1 && M1_LOCK)
      win = MST_M1;
`endif
  end

  assign win_wr    = (win == MST_M1) ? M1_WR    : M0_WR;
  assign win_addr  = (win == MST_M1) ? M1_ADDR  : M0_ADDR;
  assign win_wdata = (win == MST_M1) ? M1_WDATA : M0_WDATA;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // RF_WR_EN is high throughout ISSUE exactly when the issued command is a write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = RF_WR_EN ? IDLE : WAIT_RD;
      WAIT_RD: if (RF_RD_VALID || rd_cnt == RD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      rd_cnt <= '0;
    else if (state == ISSUE)
      rd_cnt <= '0;
    else if (state == WAIT_RD)
      rd_cnt <= rd_cnt + 8'd1;
  end

  always_comb begin
    issue_now = (state == IDLE) && any_req;
    rd_fin    = (state == WAIT_RD) && (RF_RD_VALID || rd_cnt == RD_LAST);
    rd_to     = (state == WAIT_RD) && !RF_RD_VALID && (rd_cnt == RD_LAST);
    rdata_sel = RF_RD_VALID ? RF_RD_DATA : '0;

    m0_gnt_nxt     = issue_now && (win == MST_M0);
    m1_gnt_nxt     = issue_now && (win == MST_M1);
    rf_wr_en_nxt   = issue_now && win_wr;
    rf_rd_en_nxt   = issue_now && !win_wr;
    rf_addr_nxt    = issue_now ? win_addr  : RF_ADDR;
    rf_wr_data_nxt = issue_now ? win_wdata : RF_WR_DATA;

    m0_rvalid_nxt  = rd_fin && (last_gnt == MST_M0);
    m1_rvalid_nxt  = rd_fin && (last_gnt == MST_M1);
    m0_rdata_nxt   = m0_rvalid_nxt ? rdata_sel : M0_RDATA;
    m1_rdata_nxt   = m1_rvalid_nxt ? rdata_sel : M1_RDATA;
    rd_err_nxt     = rd_to;
    busy_nxt       = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_gnt   <= MST_M1;
      M0_GNT     <= 1'b0;
      M1_GNT     <= 1'b0;
      M0_RVALID  <= 1'b0;
      M1_RVALID  <= 1'b0;
      M0_RDATA   <= '0;
      M1_RDATA   <= '0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RD_ERR     <= 1'b0;
      ARB_BUSY   <= 1'b0;
    end else begin
      if (issue_now)
        last_gnt <= win;
      M0_GNT     <= m0_gnt_nxt;
      M1_GNT     <= m1_gnt_nxt;
      M0_RVALID  <= m0_rvalid_nxt;
      M1_RVALID  <= m1_rvalid_nxt;
      M0_RDATA   <= m0_rdata_nxt;
      M1_RDATA   <= m1_rdata_nxt;
      RF_ADDR    <= rf_addr_nxt;
      RF_WR_DATA <= rf_wr_data_nxt;
      RF_WR_EN   <= rf_wr_en_nxt;
      RF_RD_EN   <= rf_rd_en_nxt;
      RD_ERR     <= rd_err_nxt;
      ARB_BUSY   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_arb.sv
// Scoreboard bench for regfile_arb: stimulus pushes expected issue/response events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_regfile_arb;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int RD_TO = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          M0_REQ = 1'b0, M0_WR = 1'b0, M1_REQ = 1'b0, M1_WR = 1'b0;
  logic [AW-1:0] M0_ADDR = '0, M1_ADDR = '0;
  logic [DW-1:0] M0_WDATA = '0, M1_WDATA = '0;
`ifdef REGFILE_ARB_LOCK_EN
  logic          M0_LOCK = 1'b0, M1_LOCK = 1'b0;
`endif
  logic          M0_GNT, M0_RVALID, M1_GNT, M1_RVALID;
  logic [DW-1:0] M0_RDATA, M1_RDATA, RF_WR_DATA;
  logic [AW-1:0] RF_ADDR;
  logic          RF_WR_EN, RF_RD_EN, RD_ERR, ARB_BUSY;
  logic [DW-1:0] RF_RD_DATA;
  logic          RF_RD_VALID;

  regfile_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(RD_TO)) dut (
    .CLK(CLK), .RST(RST),
    .M0_REQ(M0_REQ), .M0_WR(M0_WR), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
    .M1_REQ(M1_REQ), .M1_WR(M1_WR), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
`ifdef REGFILE_ARB_LOCK_EN
    .M0_LOCK(M0_LOCK), .M1_LOCK(M1_LOCK),
`endif
    .M0_GNT(M0_GNT), .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID),
    .M1_GNT(M1_GNT), .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VALID(RF_RD_VALID),
    .RD_ERR(RD_ERR), .ARB_BUSY(ARB_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            is_resp;
    bit            m1;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            err;
    int            lat;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({M0_GNT, M0_RVALID, M1_GNT, M1_RVALID, RF_WR_EN, RF_RD_EN, RD_ERR, ARB_BUSY,
                M0_RDATA, M1_RDATA, RF_ADDR, RF_WR_DATA});
  endfunction

  function automatic void exp_issue(bit m1, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    exp_t e;
    e.is_resp = 1'b0; e.m1 = m1; e.wr = wr; e.addr = a; e.data = d; e.err = 1'b0; e.lat = 0;
    q.push_back(e);
  endfunction

  function automatic void exp_resp(bit m1, logic [DW-1:0] d, bit err, int lat);
    exp_t e;
    e.is_resp = 1'b1; e.m1 = m1; e.wr = 1'b0; e.addr = '0; e.data = d; e.err = err; e.lat = lat;
    q.push_back(e);
  endfunction

  // RegFile model: write on RF_WR_EN, read data returned one cycle after RF_RD_EN.
  logic [DW-1:0] mem [16];
  bit            rf_respond = 1'b1;
  bit            stray = 1'b0;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  initial begin
    RF_RD_VALID = 1'b0;
    RF_RD_DATA  = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(negedge CLK);
      m_rd = RF_RD_EN; m_wr = RF_WR_EN; m_addr = RF_ADDR; m_wd = RF_WR_DATA;
      @(posedge CLK);
      #1;
      if (m_wr) mem[m_addr] = m_wd;
      if (m_rd && rf_respond) begin
        RF_RD_VALID = 1'b1; RF_RD_DATA = mem[m_addr];
      end else if (stray) begin
        RF_RD_VALID = 1'b1; RF_RD_DATA = 8'hFF;
      end else begin
        RF_RD_VALID = 1'b0; RF_RD_DATA = '0;
      end
    end
  end

  int   mon_cyc = 0;
  int   issue_cyc = 0;
  exp_t me;
  initial begin
    forever begin
      @(negedge CLK);
      mon_cyc++;
      if (RST) begin
        if (RF_WR_EN || RF_RD_EN || M0_GNT || M1_GNT) begin
          issue_cyc = mon_cyc;
          if (q.size() == 0 || q[0].is_resp) begin
            tests++; fails++;
            $display("FAIL unexpected_issue: got gnt0=%b gnt1=%b wr=%b rd=%b expected no issue",
                     M0_GNT, M1_GNT, RF_WR_EN, RF_RD_EN);
          end else begin
            me = q.pop_front();
            chk("issue_ctl", 64'({M0_GNT, M1_GNT, RF_WR_EN, RF_RD_EN, ARB_BUSY}),
                64'({~me.m1, me.m1, me.wr, ~me.wr, 1'b1}));
            chk("issue_addr", 64'(RF_ADDR), 64'(me.addr));
            if (me.wr) chk("issue_wdata", 64'(RF_WR_DATA), 64'(me.data));
          end
        end
        if (M0_RVALID || M1_RVALID) begin
          if (q.size() == 0 || !q[0].is_resp) begin
            tests++; fails++;
            $display("FAIL unexpected_resp: got rv0=%b rv1=%b err=%b expected no response",
                     M0_RVALID, M1_RVALID, RD_ERR);
          end else begin
            me = q.pop_front();
            chk("resp_ctl", 64'({M0_RVALID, M1_RVALID, RD_ERR, ARB_BUSY}),
                64'({~me.m1, me.m1, me.err, 1'b0}));
            chk("resp_data", 64'(me.m1 ? M1_RDATA : M0_RDATA), 64'(me.data));
            chk("resp_latency", 64'(mon_cyc - issue_cyc), 64'(me.lat));
          end
        end
      end
    end
  end

  task automatic drive_m(bit m1, bit req, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    if (m1) begin
      M1_REQ = req; M1_WR = wr; M1_ADDR = a; M1_WDATA = d;
    end else begin
      M0_REQ = req; M0_WR = wr; M0_ADDR = a; M0_WDATA = d;
    end
  endtask

  task automatic do_cmd(bit m1, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    int n;
    n = 0;
    drive_m(m1, 1'b1, wr, a, d);
    do begin
      @(negedge CLK);
      n++;
    end while (!(m1 ? M1_GNT : M0_GNT) && n < 60);
    if (!(m1 ? M1_GNT : M0_GNT)) begin
      tests++; fails++;
      $display("FAIL grant_timeout: got no grant for m%0d expected grant", m1);
    end
    drive_m(m1, 1'b0, wr, a, d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ARB_BUSY && n < 60);
    if (ARB_BUSY) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got ARB_BUSY=1 expected 0");
    end
  endtask

  int g0, g1, n, last_n;
  logic [AW-1:0] la [4];
  logic [DW-1:0] ld [4];

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", all_outs(), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_reset_outputs", all_outs(), 64'd0);

    // Single write, then idle on the following cycle.
    exp_issue(0, 1, 4'h2, 8'hA5);
    do_cmd(0, 1, 4'h2, 8'hA5);
    @(negedge CLK);
    chk("write_returns_idle", 64'(ARB_BUSY), 64'd0);
    exp_issue(1, 1, 4'h3, 8'h3C);
    do_cmd(1, 1, 4'h3, 8'h3C);
    wait_idle();

    // Reads with a one-cycle RegFile response.
    exp_issue(1, 0, 4'h3, 8'h00);
    exp_resp(1, 8'h3C, 0, 2);
    do_cmd(1, 0, 4'h3, 8'h00);
    wait_idle();
    exp_issue(0, 0, 4'h2, 8'h00);
    exp_resp(0, 8'hA5, 0, 2);
    do_cmd(0, 0, 4'h2, 8'h00);
    wait_idle();

    // Lost response: aborted after RD_TO cycles in WAIT_RD.
    rf_respond = 1'b0;
    exp_issue(0, 0, 4'h2, 8'h00);
    exp_resp(0, 8'h00, 1, RD_TO + 1);
    do_cmd(0, 0, 4'h2, 8'h00);
    wait_idle();
    rf_respond = 1'b1;
    chk("m1_rdata_hold", 64'(M1_RDATA), 64'h3C);

    // RF_RD_VALID while idle must not produce a response.
    stray = 1'b1;
    @(negedge CLK);
    stray = 1'b0;
    repeat (3) @(negedge CLK);

    // Back-to-back writes: one grant every 2 cycles.
    la[0] = 4'h5; la[1] = 4'h6; la[2] = 4'h7;
    ld[0] = 8'h11; ld[1] = 8'h22; ld[2] = 8'h33;
    for (int i = 0; i < 3; i++) exp_issue(0, 1, la[i], ld[i]);
    g0 = 0; n = 0; last_n = 0;
    drive_m(0, 1'b1, 1'b1, la[0], ld[0]);
    while (g0 < 3 && n < 60) begin
      @(negedge CLK);
      n++;
      if (M0_GNT) begin
        if (g0 > 0) chk("write_spacing", 64'(n - last_n), 64'd2);
        last_n = n;
        g0++;
        if (g0 < 3) drive_m(0, 1'b1, 1'b1, la[g0], ld[g0]);
        else drive_m(0, 1'b0, 1'b1, la[2], ld[2]);
      end
    end
    chk("write_burst_count", 64'(g0), 64'd3);
    wait_idle();

    // Reset during WAIT_RD: everything returns to zero, no strobe or response.
    rf_respond = 1'b0;
    exp_issue(0, 0, 4'h5, 8'h00);
    do_cmd(0, 0, 4'h5, 8'h00);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midop_reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    rf_respond = 1'b1;
    @(negedge CLK);

    // Both masters reading continuously: M0 wins the first tie, then alternation.
    for (int i = 0; i < 2; i++) begin
      exp_issue(0, 0, 4'h2, 8'h00); exp_resp(0, 8'hA5, 0, 2);
      exp_issue(1, 0, 4'h3, 8'h00); exp_resp(1, 8'h3C, 0, 2);
    end
    g0 = 0; g1 = 0; n = 0;
    drive_m(0, 1'b1, 1'b0, 4'h2, 8'h00);
    drive_m(1, 1'b1, 1'b0, 4'h3, 8'h00);
    while (!(g0 == 2 && g1 == 2) && n < 100) begin
      @(negedge CLK);
      n++;
      if (M0_GNT) begin g0++; if (g0 == 2) M0_REQ = 1'b0; end
      if (M1_GNT) begin g1++; if (g1 == 2) M1_REQ = 1'b0; end
    end
    chk("rr_grant_count", 64'({g0, g1}), {32'd2, 32'd2});
    wait_idle();

`ifdef REGFILE_ARB_LOCK_EN
    // M0 keeps ownership for three locked commands, then M1 gets the next grant.
    la[0] = 4'h8; la[1] = 4'h9; la[2] = 4'hA; la[3] = 4'hC;
    ld[0] = 8'h81; ld[1] = 8'h82; ld[2] = 8'h83; ld[3] = 8'h84;
    for (int i = 0; i < 3; i++) exp_issue(0, 1, la[i], ld[i]);
    exp_issue(1, 1, 4'hB, 8'h90);
    exp_issue(0, 1, la[3], ld[3]);
    g0 = 0; g1 = 0; n = 0;
    M0_LOCK = 1'b1;
    drive_m(0, 1'b1, 1'b1, la[0], ld[0]);
    drive_m(1, 1'b1, 1'b1, 4'hB, 8'h90);
    while (!(g0 == 4 && g1 == 1) && n < 100) begin
      @(negedge CLK);
      n++;
      if (M0_GNT) begin
        g0++;
        if (g0 == 3) M0_LOCK = 1'b0;
        if (g0 < 4) drive_m(0, 1'b1, 1'b1, la[g0], ld[g0]);
        else M0_REQ = 1'b0;
      end
      if (M1_GNT) begin g1++; M1_REQ = 1'b0; end
    end
    chk("lock_grant_count", 64'({g0, g1}), {32'd4, 32'd1});
    wait_idle();
`endif

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

endmodule
